// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single pipelined SDRAM controller slave.
// m0 has priority; a starvation counter forces an m1 grant; read data returns via a tag FIFO.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned MAX_PEND     = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clock,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   sd_address,
    output logic                sd_read,
    output logic                sd_write,
    output logic [DATA_W/8-1:0] sd_byteenable,
    output logic [DATA_W-1:0]   sd_writedata,
    input  logic                sd_waitrequest,
    input  logic [DATA_W-1:0]   sd_readdata,
    input  logic                sd_readdatavalid,

    output logic                protocol_error
);

    localparam int unsigned PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e state_q, state_d;

    logic m0_req, m1_req, elig0, elig1;
    logic grant0, grant1;
    logic sel_write;
    logic accept, push, pop, fifo_full, fifo_empty, head_tag;
    logic cmd_owner_q;

    logic [STV_W-1:0]    starve_q;
    logic [MAX_PEND-1:0] tag_mem_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    fifo_cnt_q;

    assign m0_req     = m0_read | m0_write;
    assign m1_req     = m1_read | m1_write;
    assign fifo_full  = (fifo_cnt_q == CNT_W'(MAX_PEND));
    assign fifo_empty = (fifo_cnt_q == '0);
    // A full tag FIFO only blocks reads; writes need no response slot.
    assign elig0      = m0_req & (m0_write | ~fifo_full);
    assign elig1      = m1_req & (m1_write | ~fifo_full);

    assign accept   = (state_q == StIssue) & ~sd_waitrequest;
    assign push     = accept & sd_read;
    assign pop      = sd_readdatavalid & ~fifo_empty;
    assign head_tag = tag_mem_q[rd_ptr_q];

    assign sel_write = grant1 ? m1_write : m0_write;

    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (!reset) begin
                    if (elig1 && starve_q == STV_W'(STARVE_LIMIT)) begin
                        grant1 = 1'b1;
                    end else if (elig0) begin
                        grant0 = 1'b1;
                    end else if (elig1) begin
                        grant1 = 1'b1;
                    end
                    if (grant0 || grant1) begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (!sd_waitrequest) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign m0_waitrequest = ~grant0;
    assign m1_waitrequest = ~grant1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Downstream command register; held stable while the controller stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            sd_address    <= '0;
            sd_read       <= 1'b0;
            sd_write      <= 1'b0;
            sd_byteenable <= '0;
            sd_writedata  <= '0;
            cmd_owner_q   <= 1'b0;
        end else if (grant0 || grant1) begin
            sd_address    <= grant1 ? m1_address    : m0_address;
            sd_byteenable <= grant1 ? m1_byteenable : m0_byteenable;
            sd_writedata  <= grant1 ? m1_writedata  : m0_writedata;
            sd_write      <= sel_write;
            sd_read       <= ~sel_write;
            cmd_owner_q   <= grant1;
        end else if (accept) begin
            sd_read  <= 1'b0;
            sd_write <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= '0;
        end else if (!m1_req || grant1) begin
            starve_q <= '0;
        end else if (grant0 && starve_q != STV_W'(STARVE_LIMIT)) begin
            starve_q <= starve_q + STV_W'(1);
        end
    end

    // In-order owner tags for outstanding reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_mem_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                tag_mem_q[wr_ptr_q] <= cmd_owner_q;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            protocol_error   <= 1'b0;
        end else begin
            m0_readdatavalid <= pop & ~head_tag;
            m1_readdatavalid <= pop & head_tag;
            if (pop && !head_tag) begin
                m0_readdata <= sd_readdata;
            end
            if (pop && head_tag) begin
                m1_readdata <= sd_readdata;
            end
            // A response with no outstanding read is dropped and flagged until reset.
            if (sd_readdatavalid && fifo_empty) begin
                protocol_error <= 1'b1;
            end
        end
    end

endmodule
